mbus_wr_arbiter: RTL

MBUS_WR_ARBITER -- requirements
Module: mbus_wr_arbiter

---
 rtl/mbus_wr_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mbus_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mbus_wr_arbiter
//
// Four-channel round-robin write arbiter in front of a DDR write controller.
// One channel at a time is granted the mbus write path. Its start address is
// latched on grant. Its data and data-request are steered combinationally
// while the controller is busy. After each transfer the arbiter holds for
// three RELEASE cycles, so that requesters that sync the busy signal through
// two stages see it drop before the next grant.
//
// Optional feature:
//   MBUS_ARB_TIMEOUT_EN -- when defined, a grant watchdog counts GRANT cycles.
//                          On reaching TIMEOUT_CYC it releases the grant and
//                          sets the sticky o_timeout flag. When undefined,
//                          GRANT waits indefinitely and o_timeout is tied low.
//
// Ports:
//   i_axi_aclk, i_rstn           clock, asynchronous active-low reset
//   i_ch_wrq / i_ch_wready       per-channel request and data-ready (4 bits)
//   i_ch_waddr / i_ch_wdata      per-channel address/data, channel n at slot n
//   o_ch_wsel                    one-hot granted channel (GRANT/BUSY)
//   o_ch_wdata_rq / o_ch_wbusy   controller handshakes forwarded to grantee
//   o_mbus_wrq/waddr/wdata/wready  request side towards the write controller
//   i_mbus_wdata_rq / i_mbus_wbusy controller data request and busy
//   o_grant_id                   current / last granted channel index
//   o_timeout                    sticky watchdog flag
// -----------------------------------------------------------------------------
module mbus_wr_arbiter #(
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_LENGTH    = 8,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic                                        i_axi_aclk,
  input  logic                                        i_rstn,
  input  logic [3:0]                                  i_ch_wrq,
  input  logic [3:0]                                  i_ch_wready,
  input  logic [4*CTRL_ADDR_WIDTH-1:0]                i_ch_waddr,
  input  logic [4*MEM_DQ_WIDTH*BURST_LENGTH-1:0]      i_ch_wdata,
  output logic [3:0]                                  o_ch_wsel,
  output logic [3:0]                                  o_ch_wdata_rq,
  output logic [3:0]                                  o_ch_wbusy,
  output logic                                        o_mbus_wrq,
  output logic [CTRL_ADDR_WIDTH-1:0]                  o_mbus_waddr,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]        o_mbus_wdata,
  output logic                                        o_mbus_wready,
  input  logic                                        i_mbus_wdata_rq,
  input  logic                                        i_mbus_wbusy,
  output logic [1:0]                                  o_grant_id,
  output logic                                        o_timeout
);

  localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 grant_q, grant_d;
  logic [1:0]                 last_grant_q, last_grant_d;
  logic [1:0]                 rel_cnt_q, rel_cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                       busy_prev_q;

  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] winner;
  logic [1:0] idx;

  // Round-robin pick. The loop scans from the lowest priority (last_grant
  // itself) down to the highest (last_grant+1), so the final hit wins.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // a variable unassigned would infer a latch.
  always_comb begin
    eligible     = i_ch_wrq & i_ch_wready;
    any_eligible = 1'b0;
    winner       = last_grant_q;
    idx          = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant_q + 2'(k);
      if (eligible[idx]) begin
        winner       = idx;
        any_eligible = 1'b1;
      end
    end
  end

`ifdef MBUS_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;
  logic       timeout_fire;
  logic       wd_expired;

  // Expiry on the TIMEOUT_CYC-th GRANT cycle.
  assign wd_expired = (wd_cnt_q == 8'(TIMEOUT_CYC - 1));
`endif

  // Next-state and datapath-register logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    waddr_d      = waddr_q;
    last_grant_d = last_grant_q;
    rel_cnt_d    = '0;
`ifdef MBUS_ARB_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d = ST_GRANT;
          grant_d = winner;
          waddr_d = i_ch_waddr[int'(winner)*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
        end
      end
      ST_GRANT: begin
        // Busy rising wins over a simultaneous request drop.
        if (i_mbus_wbusy) begin
          state_d = ST_BUSY;
        end else if (!i_ch_wrq[grant_q]) begin
          state_d = ST_RELEASE;
        end
`ifdef MBUS_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d      = ST_RELEASE;
          timeout_fire = 1'b1;
        end
`endif
      end
      ST_BUSY: begin
        // Channel request is ignored here; only busy falling ends the transfer.
        if (busy_prev_q && !i_mbus_wbusy) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == 2'd2) begin
          state_d = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_RELEASE && state_d == ST_RELEASE) begin
      last_grant_d = grant_q;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      rel_cnt_q    <= '0;
      waddr_q      <= '0;
      busy_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rel_cnt_q    <= rel_cnt_d;
      waddr_q      <= waddr_d;
      busy_prev_q  <= i_mbus_wbusy;
    end
  end

`ifdef MBUS_ARB_TIMEOUT_EN
  always_comb begin
    wd_cnt_d  = (state_q == ST_GRANT) ? wd_cnt_q + 8'd1 : '0;
    timeout_d = timeout_q | timeout_fire;
  end

  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign o_timeout          = 1'b0;
`endif

  // Output logic: decoded from registered state, data paths combinational.
  always_comb begin
    o_ch_wsel     = '0;
    o_ch_wdata_rq = '0;
    o_ch_wbusy    = '0;
    o_mbus_wrq    = 1'b0;
    o_mbus_wdata  = '0;
    o_mbus_wready = 1'b0;
    if (state_q == ST_GRANT || state_q == ST_BUSY) begin
      o_ch_wsel[grant_q] = 1'b1;
      o_mbus_wready      = i_ch_wready[grant_q];
    end
    if (state_q == ST_GRANT) begin
      o_mbus_wrq = 1'b1;
    end
    if (state_q == ST_BUSY) begin
      o_mbus_wdata           = i_ch_wdata[int'(grant_q)*DW +: DW];
      o_ch_wdata_rq[grant_q] = i_mbus_wdata_rq;
    end
    if (state_q != ST_IDLE) begin
      o_ch_wbusy[grant_q] = i_mbus_wbusy;
    end
  end

  assign o_mbus_waddr = waddr_q;
  assign o_grant_id   = grant_q;

endmodule
